// File: rtl/des_pkg.sv
// Shared DES S-box definitions: substitution tables, control-state encoding
// and the 6-bit chunk to row/column mapping.
package des_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BUSY,
    ST_DONE
  } state_t;

  // Indexed [box][row][col]. The [0:15] packing puts column 0 in the leftmost nibble.
  localparam logic [0:15][3:0] SBOX [8][4] = '{
    '{64'hE4D12FB83A6C5907, 64'h0F74E2D1A6CB9538, 64'h41E8D62BFC973A50, 64'hFC8249175B3EA06D},
    '{64'hF18E6B34972DC05A, 64'h3D47F28EC01A69B5, 64'h0E7BA4D158C6932F, 64'hD8A13F42B67C05E9},
    '{64'hA09E63F51DC7B428, 64'hD709346A285ECBF1, 64'hD6498F30B12C5AE7, 64'h1AD069874FE3B52C},
    '{64'h7DE3069A1285BC4F, 64'hD8B56F03472C1AE9, 64'hA690CB7DF13E5284, 64'h3F06A1D8945BC72E},
    '{64'h2C417AB6853FD0E9, 64'hEB2C47D150FA3986, 64'h421BAD78F9C5630E, 64'hB8C71E2D6F09A453},
    '{64'hC1AF92680D34E75B, 64'hAF427C9561DE0B38, 64'h9EF528C3704A1DB6, 64'h432C95FABE17608D},
    '{64'h4B2EF08D3C975A61, 64'hD0B7491AE35C2F86, 64'h14BDC37EAF680592, 64'h6BD814A7950FE23C},
    '{64'hD2846FB1A93E50C7, 64'h1FD8A374C56B0E92, 64'h7B419CE206ADF358, 64'h21E74A8DFC90356B}
  };

  // chunk[5] is DES bit b0. Returns {row[1:0], col[3:0]}.
  function automatic logic [5:0] sbox_row_col(input logic [5:0] chunk);
    return {chunk[5], chunk[0], chunk[4:1]};
  endfunction

endpackage

// File: rtl/des_sbox_lut.sv
// Single combinational S-box lookup. The box is selected at run time so that
// each physical lane can serve any of the eight boxes.
module des_sbox_lut
  import des_pkg::*;
(
  input  logic [2:0] box,
  input  logic [5:0] chunk,
  output logic [3:0] value
);

  logic [1:0] row;
  logic [3:0] col;

  always_comb begin
    {row, col} = sbox_row_col(chunk);
    value      = SBOX[box][row][col];
  end

endmodule

// File: rtl/des_sbox_layer.sv
// DES S-box substitution layer. LANES lookups per cycle, so a block needs
// 8/LANES BUSY cycles. Valid/ready handshakes are used on both sides.
module des_sbox_layer
  import des_pkg::*;
#(
  parameter int LANES = 2
) (
  input  logic        wClk,
  input  logic        wRst_n,
  input  logic        wInValid,
  output logic        wInReady,
  input  logic [47:0] wInData,
  output logic        wOutValid,
  input  logic        wOutReady,
  output logic [31:0] wOutData
);

  localparam int STEPS  = 8 / LANES;
  localparam int STEP_W = (STEPS > 1) ? $clog2(STEPS) : 1;

  if (LANES != 1 && LANES != 2 && LANES != 4 && LANES != 8) begin : g_lanes_check
    $error("des_sbox_layer: LANES must be 1, 2, 4 or 8");
  end

  state_t            state_reg, state_next;
  logic [STEP_W-1:0] step_reg, step_next;
  // Element 7 holds S1's chunk or nibble, because DES bit 0 is the MSB.
  logic [7:0][5:0]   in_reg, in_next;
  logic [7:0][3:0]   res_reg, res_next;

  logic [2:0] lane_box [LANES];
  logic [3:0] lane_val [LANES];

  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    assign lane_box[gi] = 3'(int'(step_reg) * LANES + gi);

    des_sbox_lut u_lut (
      .box   (lane_box[gi]),
      .chunk (in_reg[~lane_box[gi]]),
      .value (lane_val[gi])
    );
  end

  always_ff @(posedge wClk) begin
    if (!wRst_n) begin
      state_reg <= ST_IDLE;
      step_reg  <= '0;
      in_reg    <= '0;
      res_reg   <= '0;
    end else begin
      state_reg <= state_next;
      step_reg  <= step_next;
      in_reg    <= in_next;
      res_reg   <= res_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    step_next  = step_reg;
    in_next    = in_reg;
    res_next   = res_reg;
    wInReady   = 1'b0;
    wOutValid  = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        wInReady = 1'b1;
        if (wInValid) begin
          in_next    = wInData;
          step_next  = '0;
          state_next = ST_BUSY;
        end
      end

      ST_BUSY: begin
        for (int i = 0; i < LANES; i++) begin
          res_next[~lane_box[i]] = lane_val[i];
        end
        step_next = step_reg + 1'b1;
        if (step_reg == STEP_W'(STEPS - 1)) begin
          step_next  = '0;
          state_next = ST_DONE;
        end
      end

      ST_DONE: begin
        wOutValid = 1'b1;
        // Accepting while the result drains avoids an IDLE bubble.
        wInReady  = wOutReady;
        if (wOutReady) begin
          if (wInValid) begin
            in_next    = wInData;
            step_next  = '0;
            state_next = ST_BUSY;
          end else begin
            state_next = ST_IDLE;
          end
        end
      end

      default: state_next = ST_IDLE;
    endcase
  end

  assign wOutData = res_reg;

endmodule

// File: tb/tb_des_sbox_layer.sv
// Bench for des_sbox_layer: one instance per LANES value, each exercised in turn
// with directed vectors and randomized valid/ready traffic against a table model.
`timescale 1ns/1ps
module tb_des_sbox_layer;

  // FIPS 46-3 S-box tables, row-major (row*16 + col).
  localparam int SREF [8][64] = '{
    '{14,4,13,1,2,15,11,8,3,10,6,12,5,9,0,7, 0,15,7,4,14,2,13,1,10,6,12,11,9,5,3,8,
      4,1,14,8,13,6,2,11,15,12,9,7,3,10,5,0, 15,12,8,2,4,9,1,7,5,11,3,14,10,0,6,13},
    '{15,1,8,14,6,11,3,4,9,7,2,13,12,0,5,10, 3,13,4,7,15,2,8,14,12,0,1,10,6,9,11,5,
      0,14,7,11,10,4,13,1,5,8,12,6,9,3,2,15, 13,8,10,1,3,15,4,2,11,6,7,12,0,5,14,9},
    '{10,0,9,14,6,3,15,5,1,13,12,7,11,4,2,8, 13,7,0,9,3,4,6,10,2,8,5,14,12,11,15,1,
      13,6,4,9,8,15,3,0,11,1,2,12,5,10,14,7, 1,10,13,0,6,9,8,7,4,15,14,3,11,5,2,12},
    '{7,13,14,3,0,6,9,10,1,2,8,5,11,12,4,15, 13,8,11,5,6,15,0,3,4,7,2,12,1,10,14,9,
      10,6,9,0,12,11,7,13,15,1,3,14,5,2,8,4, 3,15,0,6,10,1,13,8,9,4,5,11,12,7,2,14},
    '{2,12,4,1,7,10,11,6,8,5,3,15,13,0,14,9, 14,11,2,12,4,7,13,1,5,0,15,10,3,9,8,6,
      4,2,1,11,10,13,7,8,15,9,12,5,6,3,0,14, 11,8,12,7,1,14,2,13,6,15,0,9,10,4,5,3},
    '{12,1,10,15,9,2,6,8,0,13,3,4,14,7,5,11, 10,15,4,2,7,12,9,5,6,1,13,14,0,11,3,8,
      9,14,15,5,2,8,12,3,7,0,4,10,1,13,11,6, 4,3,2,12,9,5,15,10,11,14,1,7,6,0,8,13},
    '{4,11,2,14,15,0,8,13,3,12,9,7,5,10,6,1, 13,0,11,7,4,9,1,10,14,3,5,12,2,15,8,6,
      1,4,11,13,12,3,7,14,10,15,6,8,0,5,9,2, 6,11,13,8,1,4,10,7,9,5,0,15,14,2,3,12},
    '{13,2,8,4,6,15,11,1,10,9,3,14,5,0,12,7, 1,15,13,8,10,3,7,4,12,5,6,11,0,14,9,2,
      7,11,4,1,9,12,14,2,0,6,10,13,15,3,5,8, 2,1,14,7,4,10,8,13,15,12,9,0,3,5,6,11}
  };

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [3:0]       rst_n, in_valid, out_ready;
  logic [3:0][47:0] in_data;
  wire  [3:0]       in_ready, out_valid;
  wire  [3:0][31:0] out_data;

  for (genvar gi = 0; gi < 4; gi++) begin : g_dut
    des_sbox_layer #(.LANES(1 << gi)) u_dut (
      .wClk      (clk),
      .wRst_n    (rst_n[gi]),
      .wInValid  (in_valid[gi]),
      .wInReady  (in_ready[gi]),
      .wInData   (in_data[gi]),
      .wOutValid (out_valid[gi]),
      .wOutReady (out_ready[gi]),
      .wOutData  (out_data[gi])
    );
  end

  int checks   = 0;
  int passes   = 0;
  int cur      = 0;
  int recv_cnt = 0;
  logic [31:0] exp_q [$];

  function automatic logic [31:0] model(input logic [47:0] x);
    logic [31:0] r = '0;
    for (int n = 0; n < 8; n++) begin
      int c6  = int'((x >> (42 - 6 * n)) & 48'h3F);
      int row = ((c6 >> 5) & 1) * 2 + (c6 & 1);
      int col = (c6 >> 1) & 15;
      r = {r[27:0], 4'(SREF[n][row * 16 + col])};
    end
    return r;
  endfunction

  function automatic logic [47:0] rand48();
    return {16'($urandom), 32'($urandom)};
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("FAIL %s lanes=%0d got=%0h expected=%0h", name, 1 << cur, got, exp);
  endtask

  // Scoreboard: push the model result on each input handshake, pop on each output handshake.
  logic        prev_hold = 1'b0;
  logic [31:0] prev_data = '0;
  logic [31:0] e;
  always @(negedge clk) begin
    if (!rst_n[cur]) begin
      exp_q.delete();
      prev_hold = 1'b0;
    end else begin
      if (prev_hold) begin
        check("hold_valid", out_valid[cur], 1);
        check("hold_data", out_data[cur], prev_data);
      end
      if (out_valid[cur]) begin
        check("done_in_ready", in_ready[cur], out_ready[cur]);
        if (out_ready[cur]) begin
          if (exp_q.size() == 0) begin
            check("spurious_output", exp_q.size(), 1);
          end else begin
            e = exp_q.pop_front();
            check("result", out_data[cur], e);
            recv_cnt++;
            $display("lanes=%0d blk=%0d out=%h exp=%h", 1 << cur, recv_cnt, out_data[cur], e);
          end
        end
      end
      if (in_valid[cur] && in_ready[cur]) exp_q.push_back(model(in_data[cur]));
      prev_hold = out_valid[cur] && !out_ready[cur];
      prev_data = out_data[cur];
    end
  end

  task automatic drain(input int l);
    out_ready[l] = 1'b1;
    @(posedge clk); #1;
    out_ready[l] = 1'b0;
  endtask

  task automatic wait_valid(input int l, output int lat);
    lat = 0;
    while (!out_valid[l] && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic send_block(input int l, input logic [47:0] data, input logic [31:0] exp,
                            input string name);
    int wc = 0;
    int lat;
    in_data[l]   = data;
    in_valid[l]  = 1'b1;
    out_ready[l] = 1'b0;
    while (!in_ready[l] && wc < 50) begin
      @(posedge clk); #1;
      wc++;
    end
    check({name, "_accept"}, in_ready[l], 1);
    @(posedge clk); #1;
    in_valid[l] = 1'b0;
    in_data[l]  = rand48();
    wait_valid(l, lat);
    check({name, "_latency"}, lat, 8 >> l);
    check({name, "_data"}, out_data[l], exp);
    drain(l);
  endtask

  task automatic backpressure(input int l);
    int lat;
    in_data[l]  = 48'h0;
    in_valid[l] = 1'b1;
    @(posedge clk); #1;
    in_data[l] = 48'hFFFFFFFFFFFF;
    wait_valid(l, lat);
    for (int c = 0; c < 10; c++) begin
      check("bp_in_ready", in_ready[l], 0);
      check("bp_out_valid", out_valid[l], 1);
      check("bp_data", out_data[l], 32'hEFA72C4D);
      @(posedge clk); #1;
    end
    out_ready[l] = 1'b1;
    @(posedge clk); #1;
    out_ready[l] = 1'b0;
    in_valid[l]  = 1'b0;
    check("bp_recapture_busy", out_valid[l], 0);
    wait_valid(l, lat);
    check("bp_second_latency", lat, 8 >> l);
    check("bp_second_data", out_data[l], 32'hD9CE3DCB);
    drain(l);
  endtask

  task automatic reset_mid_busy(input int l);
    in_data[l]  = 48'hFFFFFFFFFFFF;
    in_valid[l] = 1'b1;
    @(posedge clk); #1;
    in_valid[l] = 1'b0;
    rst_n[l]    = 1'b0;
    @(posedge clk); #1;
    rst_n[l]     = 1'b1;
    out_ready[l] = 1'b1;
    for (int c = 0; c < 12; c++) begin
      check("abort_out_valid", out_valid[l], 0);
      @(posedge clk); #1;
    end
    out_ready[l] = 1'b0;
    send_block(l, 48'h0, 32'hEFA72C4D, "after_reset");
  endtask

  task automatic random_run(input int l, input int n);
    int  sent = 0;
    int  cyc  = 0;
    logic acc;
    recv_cnt = 0;
    while (recv_cnt < n && cyc < 20000) begin
      if (!in_valid[l]) begin
        in_data[l] = rand48();
        if (sent < n && $urandom_range(0, 3) != 0) in_valid[l] = 1'b1;
      end
      out_ready[l] = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      acc = in_valid[l] && in_ready[l];
      @(posedge clk); #1;
      cyc++;
      if (acc) begin
        sent++;
        in_valid[l] = 1'b0;
      end
    end
    in_valid[l]  = 1'b0;
    out_ready[l] = 1'b0;
    check("random_count", recv_cnt, n);
    check("random_queue_empty", exp_q.size(), 0);
  endtask

  initial begin
    rst_n     = '0;
    in_valid  = '0;
    out_ready = '0;
    in_data   = '0;

    check("model_zero", model(48'h0), 32'hEFA72C4D);
    check("model_ones", model(48'hFFFFFFFFFFFF), 32'hD9CE3DCB);
    check("model_s5_row1", model(48'h000000040000), 32'hEFA7EC4D);

    for (int l = 0; l < 4; l++) begin
      @(posedge clk); #1;
      cur = l;
      rst_n[l] = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("reset_out_valid", out_valid[l], 0);
      check("reset_in_ready", in_ready[l], 1);
      rst_n[l] = 1'b1;
      send_block(l, 48'hFFFFFFFFFFFF, 32'hD9CE3DCB, "ones");
      send_block(l, 48'h0, 32'hEFA72C4D, "zeros");
      send_block(l, 48'h000000040000, 32'hEFA7EC4D, "s5_row1");
      backpressure(l);
      reset_mid_busy(l);
      random_run(l, 1000);
      rst_n[l] = 1'b0;
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
